// File: rtl/riscv_pkg.sv
// Shared RISC-V datapath types: access sizes, load/store unit states and byte-mask helpers.
package riscv_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    SIZE_B = 2'b00,
    SIZE_H = 2'b01,
    SIZE_W = 2'b10
  } mem_size_e;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE0,
    WAIT0,
    ISSUE1,
    WAIT1,
    RESP
  } lsu_state_e;

  function automatic logic [3:0] size_mask(input logic [1:0] size);
    case (size)
      SIZE_B:  return 4'b0001;
      SIZE_H:  return 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  // True when the access spills past the end of its word and needs a second beat.
  function automatic logic crosses_word(input logic [1:0] size, input logic [1:0] offset);
    return ((size == SIZE_W) && (offset != 2'b00)) ||
           ((size == SIZE_H) && (offset == 2'b11));
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Combinational load aligner: picks the addressed bytes out of a {hi, lo} word pair
// and sign- or zero-extends them to the full data width.
module lsu_load_align
  import riscv_pkg::*;
#(
  parameter int DATA_W = XLEN
) (
  input  logic [DATA_W-1:0] hi,
  input  logic [DATA_W-1:0] lo,
  input  logic [1:0]        offset,
  input  logic [1:0]        size,
  input  logic              is_unsigned,
  output logic [DATA_W-1:0] result
);

  logic [DATA_W-1:0] r;

  always_comb begin
    r = DATA_W'({hi, lo} >> {offset, 3'b000});
    case (size)
      SIZE_B:  result = is_unsigned ? {{(DATA_W-8){1'b0}}, r[7:0]}
                                    : {{(DATA_W-8){r[7]}}, r[7:0]};
      SIZE_H:  result = is_unsigned ? {{(DATA_W-16){1'b0}}, r[15:0]}
                                    : {{(DATA_W-16){r[15]}}, r[15:0]};
      default: result = r;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: turns one core access into one or two word-aligned memory beats.
// Build option MISALIGNED_TRAP_EN: word-crossing accesses return an error instead of splitting.
module load_store_unit
  import riscv_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = XLEN
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_error,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata
);

`ifdef MISALIGNED_TRAP_EN
  localparam bit TRAP_MISALIGNED = 1'b1;
`else
  localparam bit TRAP_MISALIGNED = 1'b0;
`endif

  lsu_state_e state;

  logic              write_q;
  logic              uns_q;
  logic              split_q;
  logic [1:0]        size_q;
  logic [1:0]        off_q;
  logic [ADDR_W-1:0] addr_q;
  logic [3:0]        be_hi_q;
  logic [DATA_W-1:0] wdata_hi_q;
  logic [DATA_W-1:0] lo_q;

  logic [7:0]          m8;
  logic [2*DATA_W-1:0] w64;
  logic                req_split;
  logic                req_illegal;
  logic [DATA_W-1:0]   align_hi;
  logic [DATA_W-1:0]   align_lo;
  logic [DATA_W-1:0]   load_result;

  always_comb begin
    m8          = {4'b0000, size_mask(req_size)} << req_addr[1:0];
    w64         = {{DATA_W{1'b0}}, req_wdata} << {req_addr[1:0], 3'b000};
    req_split   = crosses_word(req_size, req_addr[1:0]);
    req_illegal = (req_size == 2'b11) || (TRAP_MISALIGNED && req_split);
  end

  // The word arriving this cycle is used directly so the result can be registered at once.
  always_comb begin
    align_lo = (state == WAIT1) ? lo_q : mem_rdata;
    align_hi = (state == WAIT1) ? mem_rdata : '0;
  end

  lsu_load_align #(
    .DATA_W(DATA_W)
  ) u_load_align (
    .hi         (align_hi),
    .lo         (align_lo),
    .offset     (off_q),
    .size       (size_q),
    .is_unsigned(uns_q),
    .result     (load_result)
  );

  assign req_ready = (state == IDLE);

  // Request capture and read-data holding registers
  always_ff @(posedge clk) begin
    if (state == IDLE && req_valid) begin
      write_q    <= req_write;
      uns_q      <= req_unsigned;
      split_q    <= req_split;
      size_q     <= req_size;
      off_q      <= req_addr[1:0];
      addr_q     <= {req_addr[ADDR_W-1:2], 2'b00};
      be_hi_q    <= m8[7:4];
      wdata_hi_q <= w64[2*DATA_W-1:DATA_W];
    end
    if (state == WAIT0 && mem_rvalid) begin
      lo_q <= mem_rdata;
    end
  end

  // Control FSM with registered memory and response outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      resp_valid    <= 1'b0;
      resp_rdata    <= '0;
      resp_error    <= 1'b0;
      mem_req_valid <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_be        <= 4'b0000;
      mem_wdata     <= '0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            if (req_illegal) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_error <= 1'b1;
              resp_rdata <= '0;
            end else begin
              state         <= ISSUE0;
              mem_req_valid <= 1'b1;
              mem_we        <= req_write;
              mem_addr      <= {req_addr[ADDR_W-1:2], 2'b00};
              mem_be        <= m8[3:0];
              mem_wdata     <= w64[DATA_W-1:0];
            end
          end
        end
        ISSUE0: begin
          if (mem_req_ready) begin
            if (write_q && split_q) begin
              state     <= ISSUE1;
              mem_addr  <= addr_q + ADDR_W'(4);
              mem_be    <= be_hi_q;
              mem_wdata <= wdata_hi_q;
            end else if (write_q) begin
              state         <= RESP;
              mem_req_valid <= 1'b0;
              resp_valid    <= 1'b1;
              resp_error    <= 1'b0;
              resp_rdata    <= '0;
            end else begin
              state         <= WAIT0;
              mem_req_valid <= 1'b0;
            end
          end
        end
        WAIT0: begin
          if (mem_rvalid) begin
            if (split_q) begin
              state         <= ISSUE1;
              mem_req_valid <= 1'b1;
              mem_addr      <= addr_q + ADDR_W'(4);
              mem_be        <= be_hi_q;
              mem_wdata     <= wdata_hi_q;
            end else begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_error <= 1'b0;
              resp_rdata <= load_result;
            end
          end
        end
        ISSUE1: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            if (write_q) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_error <= 1'b0;
              resp_rdata <= '0;
            end else begin
              state <= WAIT1;
            end
          end
        end
        WAIT1: begin
          if (mem_rvalid) begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_error <= 1'b0;
            resp_rdata <= load_result;
          end
        end
        RESP: begin
          state      <= IDLE;
          resp_rdata <= '0;
          resp_error <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
